cr_prefix_rec_nn_engine: RTL
============================

CR_PREFIX_REC_NN_ENGINE -- requirements
Module: cr_prefix_rec_nn_engine

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  N_NEURONS, 16, neuron lanes (power of 2, 2..128)
  NEURON_WIDTH, 8, signed feature/coeff width
  ACC_WIDTH, 20, signed accumulator width (>= 2*NEURON_WIDTH)
  FEAT_CNT_WIDTH, 10, width of per-job feature count
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  sole clock
  rst_n  in  1  reset, asynchronous, active-low
  start  in  1  job start pulse, sampled in IDLE only
  cfg_feat_cnt  in  FEAT_CNT_WIDTH  features per job, latched on start
  cfg_threshold  in  NEURON_WIDTH  signed hit threshold, latched on start
  in_valid  in  1  feature beat valid
  in_ready  out  1  feature beat accepted when in_valid & in_ready
  in_feature  in  NEURON_WIDTH  signed feature value
  in_coeff  in  N_NEURONS*NEURON_WIDTH  signed per-lane coefficients, lane k at bits [k*NW +: NW]
  out_valid  out  1  result valid
  out_ready  in  1  result consumed when out_valid & out_ready
  out_prefix  out  $clog2(N_NEURONS)  winning lane index
  out_hit  out  1  winner score > threshold
  out_score  out  NEURON_WIDTH  winning activated score
  busy  out  1  high in any state other than IDLE
  sat_err  out  1  sticky lane-saturation flag for the current job

Function
REQ-003 FSM states SHALL be IDLE, ACCUM, ACT, ARGMAX, OUT.
REQ-004 IDLE->ACCUM on start with cfg_feat_cnt!=0; IDLE->ACT on start with cfg_feat_cnt==0. All accumulators, the beat counter and sat_err clear on that start cycle.
REQ-005 start outside IDLE SHALL be ignored.
REQ-006 in_ready SHALL be high exactly in ACCUM.
REQ-007 Each accepted beat: acc[k] += in_feature*coeff[k] (signed, full product sign-extended to ACC_WIDTH).
REQ-008 Beat counter SHALL increment per accepted beat; ACCUM->ACT on the cycle after the beat that reaches cfg_feat_cnt.
REQ-009 ACT (1 cycle): act[k] = clamp(acc[k], 0, 2^(NEURON_WIDTH-1)-1) (ReLU plus saturation).
REQ-010 ARGMAX: one lane compared per cycle, lane 0 first, N_NEURONS cycles. Strictly greater replaces the current best, so ties resolve to the lowest index.
REQ-011 ARGMAX->OUT after lane N_NEURONS-1. out_hit = signed(best score) > signed(cfg_threshold).
REQ-012 Latency: last beat accepted in cycle t -> out_valid high in cycle t+2+N_NEURONS.
REQ-013 OUT: out_valid high; out_prefix/out_hit/out_score held stable while out_ready is low; OUT->IDLE on handshake.
REQ-014 Outside OUT, out_valid SHALL be 0 and out_prefix/out_hit/out_score SHALL hold their last values.
REQ-015 A start in the same cycle as the OUT handshake SHALL be ignored. start is accepted from the following IDLE cycle.

Reset
REQ-016 rst_n low SHALL asynchronously force: IDLE, all accumulators 0, in_ready=0, out_valid=0, out_prefix=0, out_hit=0, out_score=0, busy=0, sat_err=0.
REQ-017 Reset mid-job SHALL abandon the job with no output produced; the first post-reset job SHALL be unaffected.

Configuration
REQ-018 Macro CR_PREFIX_REC_NN_SAT_EN:
  - Defined: each accumulate saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and sets sat_err on any clip.
  - Undefined: accumulation wraps two's-complement and sat_err is tied to 0.

Verification (N_NEURONS=16, NEURON_WIDTH=8, ACC_WIDTH=20)
REQ-019 Job: feat_cnt=2, features 3,4; coeff lane5=10, others 1; threshold=20 -> out_prefix=5, out_score=70, out_hit=1; out_valid exactly 18 cycles after the 2nd beat.
REQ-020 feat_cnt=0, threshold=-1 -> ACCUM skipped; out_prefix=0, out_score=0, out_hit=1. Same job with threshold=0 -> out_hit=0.
REQ-021 Tie: lanes 3 and 9 both reach act 50, all others lower -> out_prefix=3. Holding out_ready=0 for 10 cycles -> outputs stable; start pulses while busy are ignored.
REQ-022 SAT_EN defined, 200 beats of feature=127 with coeff lane0=127 -> lane0 acc pinned at 524287, sat_err=1, out_score=127. SAT_EN undefined, same stimulus -> lane0 acc wraps, sat_err=0.
REQ-023 rst_n asserted in ARGMAX -> all outputs at reset values immediately (asynchronously); a following job with REQ-019 stimulus gives the REQ-019 result.
REQ-024 Random in_valid gaps (~50% duty) over a 64-beat job -> result matches the reference model; only beats with in_valid & in_ready are accumulated.

Source files
------------

// File: rtl/cr_prefix_rec_nn_engine.sv
// cr_prefix_rec_nn_engine: multi-lane MAC neuron engine with ReLU/saturation and serial argmax.
// Define CR_PREFIX_REC_NN_SAT_EN for saturating accumulators and a sticky sat_err; otherwise accumulators wrap.
module cr_prefix_rec_nn_engine #(
  parameter int N_NEURONS      = 16,
  parameter int NEURON_WIDTH   = 8,
  parameter int ACC_WIDTH      = 20,
  parameter int FEAT_CNT_WIDTH = 10,
  localparam int PW            = $clog2(N_NEURONS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [FEAT_CNT_WIDTH-1:0]         cfg_feat_cnt,
  input  logic signed [NEURON_WIDTH-1:0]    cfg_threshold,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [NEURON_WIDTH-1:0]    in_feature,
  input  logic [N_NEURONS*NEURON_WIDTH-1:0] in_coeff,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [PW-1:0]                     out_prefix,
  output logic                              out_hit,
  output logic [NEURON_WIDTH-1:0]           out_score,
  output logic                              busy,
  output logic                              sat_err
);
  typedef enum logic [2:0] {IDLE, ACCUM, ACT, ARGMAX, OUT} state_t;
  localparam logic signed [ACC_WIDTH-1:0] ACT_MAX = ACC_WIDTH'(2**(NEURON_WIDTH-1)-1);
  state_t                         state_q;
  logic signed [ACC_WIDTH-1:0]    acc_q [N_NEURONS];
  logic signed [ACC_WIDTH-1:0]    acc_d [N_NEURONS];
  logic [NEURON_WIDTH-1:0]        act_q [N_NEURONS];
  logic [NEURON_WIDTH-1:0]        act_d [N_NEURONS];
  logic [N_NEURONS-1:0]           clip;
  logic [FEAT_CNT_WIDTH-1:0]      cnt_q, feat_cnt_q;
  logic signed [NEURON_WIDTH-1:0] thr_q;
  logic [PW-1:0]                  lane_q, best_idx_q, best_idx_d, out_prefix_q;
  logic [NEURON_WIDTH-1:0]        best_q, best_d, out_score_q;
  logic                           out_hit_q, sat_q, take;
  for (genvar k = 0; k < N_NEURONS; k++) begin : g_lane
    logic signed [2*NEURON_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]      prod_ext;
    assign prod     = in_feature * $signed(in_coeff[k*NEURON_WIDTH +: NEURON_WIDTH]);
    assign prod_ext = {{(ACC_WIDTH-2*NEURON_WIDTH){prod[2*NEURON_WIDTH-1]}}, prod};
`ifdef CR_PREFIX_REC_NN_SAT_EN
    logic [ACC_WIDTH:0] sum;
    assign sum      = {acc_q[k][ACC_WIDTH-1], acc_q[k]} + {prod_ext[ACC_WIDTH-1], prod_ext};
    assign clip[k]  = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    assign acc_d[k] = !clip[k] ? sum[ACC_WIDTH-1:0] :
                      sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
    assign clip[k]  = 1'b0;
    assign acc_d[k] = acc_q[k] + prod_ext;
`endif
    // ReLU followed by clamp to the largest positive NEURON_WIDTH value
    assign act_d[k] = acc_q[k][ACC_WIDTH-1] ? '0 :
                      acc_q[k] > ACT_MAX ? ACT_MAX[NEURON_WIDTH-1:0] : acc_q[k][NEURON_WIDTH-1:0];
  end
  // lane 0 always seeds the best; later lanes need strictly greater so ties keep the lowest index
  assign take       = lane_q == '0 || act_q[lane_q] > best_q;
  assign best_d     = take ? act_q[lane_q] : best_q;
  assign best_idx_d = take ? lane_q : best_idx_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      for (int i = 0; i < N_NEURONS; i++) begin
        acc_q[i] <= '0;
        act_q[i] <= '0;
      end
      cnt_q        <= '0;
      feat_cnt_q   <= '0;
      thr_q        <= '0;
      lane_q       <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      out_prefix_q <= '0;
      out_score_q  <= '0;
      out_hit_q    <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q    <= cfg_feat_cnt == '0 ? ACT : ACCUM;
          feat_cnt_q <= cfg_feat_cnt;
          thr_q      <= cfg_threshold;
          cnt_q      <= '0;
          sat_q      <= 1'b0;
          for (int i = 0; i < N_NEURONS; i++) acc_q[i] <= '0;
        end
        ACCUM: if (in_valid) begin
          for (int i = 0; i < N_NEURONS; i++) acc_q[i] <= acc_d[i];
          cnt_q <= cnt_q + 1'b1;
          sat_q <= sat_q | (|clip);
          if (cnt_q + 1'b1 == feat_cnt_q) state_q <= ACT;
        end
        ACT: begin
          for (int i = 0; i < N_NEURONS; i++) act_q[i] <= act_d[i];
          lane_q  <= '0;
          state_q <= ARGMAX;
        end
        ARGMAX: begin
          best_q     <= best_d;
          best_idx_q <= best_idx_d;
          lane_q     <= lane_q + 1'b1;
          if (&lane_q) begin
            out_prefix_q <= best_idx_d;
            out_score_q  <= best_d;
            out_hit_q    <= $signed(best_d) > thr_q;
            state_q      <= OUT;
          end
        end
        OUT: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready   = state_q == ACCUM;
  assign out_valid  = state_q == OUT;
  assign busy       = state_q != IDLE;
  assign out_prefix = out_prefix_q;
  assign out_score  = out_score_q;
  assign out_hit    = out_hit_q;
  assign sat_err    = sat_q;
endmodule
